// File: rtl/jtframe_snd_pkg.sv
// Shared definitions for the multichannel sound DAC: fade FSM states and
// gain constants used by the top and every channel slice.
// No ports; imported with `import jtframe_snd_pkg::*;`.
package jtframe_snd_pkg;

  // Gain register width and the value that gives bit-exact unity.
  localparam int GAIN_W = 7;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 7'd64;
  // Gain is applied as (s*g)>>>GAIN_SHIFT, so GAIN_UNITY == 2**GAIN_SHIFT.
  localparam int GAIN_SHIFT = 6;

  typedef enum logic [1:0] {
    MUTED    = 2'd0,
    FADE_IN  = 2'd1,
    RUN      = 2'd2,
    FADE_OUT = 2'd3
  } snd_state_t;

endpackage

// File: rtl/jtframe_snddac_ch.sv
// One audio channel: sample latch, gain scaling and a 1-bit modulator.
// Latency: 2 clk_sys from snd_cen to the modulator input (latch, scale).
// No backpressure: snd is taken on every snd_cen, the modulator runs every clock.
// Ports: clk_sys/rst_n (sync, active-low), snd_cen + snd (sample in),
//        gain (shared fade gain, 0..64), dac (1-bit density output).
// Macro JTFRAME_SNDDAC_ORDER2_EN selects a second-order CIFB modulator
// instead of the default first-order accumulator.
module jtframe_snddac_ch
  import jtframe_snd_pkg::*;
#(
  parameter int SNDW       = 16,
  parameter bit SIGNED_SND = 1'b0
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              snd_cen,
  input  logic [SNDW-1:0]   snd,
  input  logic [GAIN_W-1:0] gain,
  output logic              dac
);

  localparam logic [SNDW-1:0] MIDSCALE = {1'b1, {(SNDW-1){1'b0}}};

  logic [SNDW-1:0]             latch;
  logic [SNDW-1:0]             scaled;      // offset binary, feeds the modulator
  logic [SNDW-1:0]             scaled_nx;
  logic signed [SNDW-1:0]      s_in;
  logic signed [SNDW+GAIN_W:0] s_ext;
  logic signed [SNDW+GAIN_W:0] g_ext;
  logic signed [SNDW+GAIN_W:0] prod;
  logic [SNDW-1:0]             s_scaled;
  logic [GAIN_W:0]             unused_prod_bits;

  always_comb begin
    s_in = latch;
    if (!SIGNED_SND) s_in[SNDW-1] = ~latch[SNDW-1];
    s_ext = {{(GAIN_W+1){s_in[SNDW-1]}}, s_in};
    g_ext = {{(SNDW+1){1'b0}}, gain};
    prod  = s_ext * g_ext;
    // Taking the slice above GAIN_SHIFT is the arithmetic shift; |s*g/64| <= |s|
    // so the result always fits back into SNDW bits.
    s_scaled  = prod[SNDW-1+GAIN_SHIFT:GAIN_SHIFT];
    scaled_nx = {~s_scaled[SNDW-1], s_scaled[SNDW-2:0]};
  end

  assign unused_prod_bits = {prod[SNDW+GAIN_W:SNDW+GAIN_SHIFT], prod[GAIN_SHIFT-1:0]};

  // Scale register resets to midscale, i.e. the scaled value of a zero latch at g=0.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      latch  <= '0;
      scaled <= MIDSCALE;
    end else begin
      if (snd_cen) latch <= snd;
      scaled <= scaled_nx;
    end
  end

`ifdef JTFRAME_SNDDAC_ORDER2_EN
  localparam int IW = SNDW + 4;
  localparam logic signed [IW-1:0] FB_POS = {4'b0, 1'b1, {(SNDW-1){1'b0}}};
  localparam logic signed [IW-1:0] FB_NEG = -FB_POS;

  logic signed [IW-1:0] int1;
  logic signed [IW-1:0] int2;
  logic signed [IW-1:0] int1_nx;
  logic signed [IW-1:0] int2_nx;
  logic signed [IW-1:0] v_ext;
  logic signed [IW-1:0] fb;
  logic                 dac_q;

  always_comb begin
    // Back to two's complement for the bipolar loop.
    v_ext   = {{4{~scaled[SNDW-1]}}, ~scaled[SNDW-1], scaled[SNDW-2:0]};
    fb      = dac_q ? FB_POS : FB_NEG;
    int1_nx = int1 + v_ext - fb;
    int2_nx = int2 + int1_nx - fb;
  end

  // dac_q mirrors NOT MSB of integrator 2 but is forced low in reset.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      int1  <= '0;
      int2  <= '0;
      dac_q <= 1'b0;
    end else begin
      int1  <= int1_nx;
      int2  <= int2_nx;
      dac_q <= ~int2_nx[IW-1];
    end
  end

  assign dac = dac_q;
`else
  logic [SNDW:0] acc;

  // Carry out of the SNDW-bit sum is the output bit; it is dropped on the next add.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) acc <= '0;
    else        acc <= {1'b0, acc[SNDW-1:0]} + {1'b0, scaled};
  end

  assign dac = acc[SNDW];
`endif

endmodule

// File: rtl/jtframe_snddac_mc.sv
// Multichannel 1-bit sound DAC with soft mute: shared fade FSM and gain,
// one jtframe_snddac_ch per channel.
// Latency: 2 clk_sys from snd_cen to the modulators; no backpressure.
// Ports: clk_sys, rst_n (sync, active-low), snd_cen/snd (CHANNELS*SNDW),
//        mute (level), dac (per channel), muted, fade_busy.
// Macro JTFRAME_SNDDAC_ORDER2_EN switches every channel to a second-order modulator.
module jtframe_snddac_mc
  import jtframe_snd_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int SNDW       = 16,
  parameter bit SIGNED_SND = 1'b0,
  parameter int FADEW      = 8
) (
  input  logic                     clk_sys,
  input  logic                     rst_n,
  input  logic                     snd_cen,
  input  logic [CHANNELS*SNDW-1:0] snd,
  input  logic                     mute,
  output logic [CHANNELS-1:0]      dac,
  output logic                     muted,
  output logic                     fade_busy
);

  localparam logic [FADEW-1:0] PRESC_MAX = '1;

  snd_state_t        state, state_nx;
  logic [GAIN_W-1:0] g, g_nx;
  logic [FADEW-1:0]  presc, presc_nx;
  logic              wrap;

  assign wrap = (presc == PRESC_MAX);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state <= MUTED;
      g     <= '0;
      presc <= '0;
    end else begin
      state <= state_nx;
      g     <= g_nx;
      presc <= presc_nx;
    end
  end

  // presc_nx defaults to 0, which both holds it outside fades and clears it
  // on every transition (a wrap-triggered transition lands on 0 anyway).
  always_comb begin
    state_nx = state;
    g_nx     = g;
    presc_nx = '0;
    case (state)
      MUTED: begin
        if (!mute) state_nx = FADE_IN;
      end
      RUN: begin
        if (mute) state_nx = FADE_OUT;
      end
      FADE_IN: begin
        if (mute) begin
          state_nx = FADE_OUT;
        end else if (g == GAIN_UNITY) begin
          state_nx = RUN;
        end else begin
          presc_nx = presc + 1'b1;
          if (wrap) begin
            g_nx = g + 1'b1;
            if (g == GAIN_UNITY - 1'b1) state_nx = RUN;
          end
        end
      end
      FADE_OUT: begin
        if (!mute) begin
          state_nx = FADE_IN;
        end else if (g == '0) begin
          state_nx = MUTED;
        end else begin
          presc_nx = presc + 1'b1;
          if (wrap) begin
            g_nx = g - 1'b1;
            if (g == 7'd1) state_nx = MUTED;
          end
        end
      end
      default: begin
        state_nx = MUTED;
        g_nx     = '0;
      end
    endcase
  end

  always_comb begin
    muted     = (state == MUTED);
    fade_busy = (state == FADE_IN) || (state == FADE_OUT);
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    jtframe_snddac_ch #(
      .SNDW      (SNDW),
      .SIGNED_SND(SIGNED_SND)
    ) u_ch (
      .clk_sys(clk_sys),
      .rst_n  (rst_n),
      .snd_cen(snd_cen),
      .snd    (snd[k*SNDW +: SNDW]),
      .gain   (g),
      .dac    (dac[k])
    );
  end

endmodule

// File: tb/tb_jtframe_snddac_mc.sv
// Bench for jtframe_snddac_mc: three instances (offset-binary slow fade,
// offset-binary fast fade, two's-complement fast fade) against a behavioural model.
module tb_jtframe_snddac_mc;

  localparam int S_MUTED = 0, S_FIN = 1, S_RUN = 2, S_FOUT = 3;
  localparam int FULL = 65536, HALF = 32768;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cen_a, cen_bc, mute_a, mute_bc;
  logic [31:0] snd_a, snd_bc;
  logic [1:0]  dac_a, dac_b, dac_c;
  logic        muted_a, muted_b, muted_c, busy_a, busy_b, busy_c;

  jtframe_snddac_mc #(.CHANNELS(2), .SNDW(16), .SIGNED_SND(1'b0), .FADEW(8)) u_a (
    .clk_sys(clk), .rst_n(rst_n), .snd_cen(cen_a), .snd(snd_a), .mute(mute_a),
    .dac(dac_a), .muted(muted_a), .fade_busy(busy_a));
  jtframe_snddac_mc #(.CHANNELS(2), .SNDW(16), .SIGNED_SND(1'b0), .FADEW(2)) u_b (
    .clk_sys(clk), .rst_n(rst_n), .snd_cen(cen_bc), .snd(snd_bc), .mute(mute_bc),
    .dac(dac_b), .muted(muted_b), .fade_busy(busy_b));
  jtframe_snddac_mc #(.CHANNELS(2), .SNDW(16), .SIGNED_SND(1'b1), .FADEW(2)) u_c (
    .clk_sys(clk), .rst_n(rst_n), .snd_cen(cen_bc), .snd(snd_bc), .mute(mute_bc),
    .dac(dac_c), .muted(muted_c), .fade_busy(busy_c));

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  int m_latch [3][2];
  int m_scaled[3][2];
  int m_acc   [3][2];
  int m_g [3];
  int m_st[3];
  int m_pc[3];
  int m_period[3] = '{256, 4, 4};
  bit m_signed[3] = '{1'b0, 1'b0, 1'b1};

  function automatic int to_value(input int i, input int raw);
    if (m_signed[i]) return (raw >= HALF) ? raw - FULL : raw;
    return raw - HALF;
  endfunction

  task automatic model_step(input int i, input bit r, input bit cen,
                            input logic [31:0] s, input bit mu);
    int prod;
    if (!r) begin
      for (int c = 0; c < 2; c++) begin
        m_latch[i][c] = 0; m_scaled[i][c] = HALF; m_acc[i][c] = 0;
      end
      m_g[i] = 0; m_st[i] = S_MUTED; m_pc[i] = 0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      m_acc[i][c] = (m_acc[i][c] % FULL) + m_scaled[i][c];
      prod = to_value(i, m_latch[i][c]) * m_g[i];
      m_scaled[i][c] = (prod >>> 6) + HALF;
      if (cen) m_latch[i][c] = int'(s[c*16 +: 16]);
    end
    case (m_st[i])
      S_MUTED: if (!mu) m_st[i] = S_FIN;
      S_RUN:   if (mu)  m_st[i] = S_FOUT;
      S_FIN: begin
        if (mu) begin m_st[i] = S_FOUT; m_pc[i] = 0; end
        else if (m_g[i] == 64) begin m_st[i] = S_RUN; m_pc[i] = 0; end
        else begin
          m_pc[i] += 1;
          if (m_pc[i] == m_period[i]) begin
            m_pc[i] = 0; m_g[i] += 1;
            if (m_g[i] == 64) m_st[i] = S_RUN;
          end
        end
      end
      default: begin
        if (!mu) begin m_st[i] = S_FIN; m_pc[i] = 0; end
        else if (m_g[i] == 0) begin m_st[i] = S_MUTED; m_pc[i] = 0; end
        else begin
          m_pc[i] += 1;
          if (m_pc[i] == m_period[i]) begin
            m_pc[i] = 0; m_g[i] -= 1;
            if (m_g[i] == 0) m_st[i] = S_MUTED;
          end
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    model_step(0, rst_n, cen_a,  snd_a,  mute_a);
    model_step(1, rst_n, cen_bc, snd_bc, mute_bc);
    model_step(2, rst_n, cen_bc, snd_bc, mute_bc);
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_rng(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s got=%0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic cmp_dut(input int i, input logic [3:0] got);
    logic [3:0] exp;
    exp[3] = (m_st[i] == S_MUTED);
    exp[2] = (m_st[i] == S_FIN) || (m_st[i] == S_FOUT);
    exp[1] = (m_acc[i][1] >= FULL);
    exp[0] = (m_acc[i][0] >= FULL);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL outputs dut%0d t=%0t {muted,busy,dac} got=%b expected=%b", i, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, {muted_a, busy_a, dac_a});
      cmp_dut(1, {muted_b, busy_b, dac_b});
      cmp_dut(2, {muted_c, busy_c, dac_c});
    end
  end

  // ---------------- stimulus ----------------
  task automatic rand_a();
    snd_a = $urandom;
    cen_a = ($urandom_range(0, 3) == 0);
  endtask

  task automatic proc_a();
    int cnt;
    @(negedge clk);
    check_eq("a_busy_after_1clk", int'(busy_a), 1);
    check_eq("a_muted_in_fade", int'(muted_a), 0);
    for (int n = 0; n < 16383; n++) begin rand_a(); @(negedge clk); end
    check_eq("a_busy_before_run", int'(busy_a), 1);
    rand_a(); @(negedge clk);
    check_eq("a_busy_at_run", int'(busy_a), 0);
    check_eq("a_muted_at_run", int'(muted_a), 0);
    check_eq("model_g_unity", m_g[0], 64);
    check_eq("model_state_run", m_st[0], S_RUN);
    for (int n = 0; n < 500; n++) begin rand_a(); @(negedge clk); end
    mute_a = 1'b1;
    cnt = 0;
    do begin rand_a(); @(negedge clk); cnt++; end while (m_g[0] != 40 && cnt < 10000);
    check_eq("a_fadeout_to_g40_clocks", cnt, 6145);
    check_eq("a_busy_fadeout", int'(busy_a), 1);
    mute_a = 1'b0;
    rand_a(); @(negedge clk);
    check_eq("a_busy_reversed", int'(busy_a), 1);
    check_eq("model_g_no_jump", m_g[0], 40);
    check_eq("model_state_fadein", m_st[0], S_FIN);
    cnt = 1;
    while (busy_a && cnt < 10000) begin rand_a(); @(negedge clk); cnt++; end
    check_eq("a_fadein_from_40_clocks", cnt, 6145);
    check_eq("a_muted_after_refade", int'(muted_a), 0);
    mute_a = 1'b1;
  endtask

  task automatic proc_bc();
    int cnt, b0, b1, c0, c1;
    @(negedge clk);
    cnt = 1;
    while (busy_b && cnt < 2000) begin @(negedge clk); cnt++; end
    check_eq("b_fadein_clocks", cnt, 257);
    check_eq("c_busy_at_run", int'(busy_c), 0);
    repeat (8) @(negedge clk);
    b0 = 0; b1 = 0; c0 = 0; c1 = 0;
    for (int n = 0; n < 65536; n++) begin
      @(negedge clk);
      b0 += int'(dac_b[0]); b1 += int'(dac_b[1]);
      c0 += int'(dac_c[0]); c1 += int'(dac_c[1]);
    end
    check_rng("b_ch0_C000_density75", b0, 49152 - 65, 49152 + 65);
    check_rng("b_ch1_8000_density50", b1, 32767, 32769);
    check_rng("c_ch0_C000_density25", c0, 16383, 16385);
    check_eq("c_ch1_8000_ones", c1, 0);
    mute_bc = 1'b1;
  endtask

  initial begin
    int ones[6];
    rst_n = 1'b0; mute_a = 1'b0; mute_bc = 1'b0;
    snd_a = '0; cen_a = 1'b0; cen_bc = 1'b1;
    snd_bc = {16'h8000, 16'hC000};
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_eq("reset_muted", int'({muted_a, muted_b, muted_c}), 7);
    check_eq("reset_busy", int'({busy_a, busy_b, busy_c}), 0);
    check_eq("reset_dac", int'({dac_a, dac_b, dac_c}), 0);
    rst_n = 1'b1;
    fork
      proc_a();
      proc_bc();
    join
    // Bring instance A into the middle of a fade-out, then reset it there.
    mute_a = 1'b0;
    repeat (2000) @(negedge clk);
    mute_a = 1'b1;
    repeat (600) @(negedge clk);
    check_eq("a_mid_fadeout_busy", int'(busy_a), 1);
    check_eq("model_mid_fadeout", m_st[0], S_FOUT);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_mid_fade_muted", int'({muted_a, muted_b, muted_c}), 7);
    check_eq("rst_mid_fade_busy", int'({busy_a, busy_b, busy_c}), 0);
    check_eq("rst_mid_fade_dac", int'({dac_a, dac_b, dac_c}), 0);
    check_eq("model_g_after_rst", m_g[0], 0);
    for (int k = 0; k < 6; k++) ones[k] = 0;
    for (int n = 0; n < 512; n++) begin
      rand_a();
      snd_bc = $urandom;
      cen_bc = $urandom_range(0, 1) == 1;
      @(negedge clk);
      ones[0] += int'(dac_a[0]); ones[1] += int'(dac_a[1]);
      ones[2] += int'(dac_b[0]); ones[3] += int'(dac_b[1]);
      ones[4] += int'(dac_c[0]); ones[5] += int'(dac_c[1]);
    end
    for (int k = 0; k < 6; k++) check_eq($sformatf("muted_density50_ch%0d", k), ones[k], 256);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtframe_snddac_mc.md
JTFRAME_SNDDAC_MC -- requirements
Module: jtframe_snddac_mc

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent audio channels, 1..4.
REQ-002 SHALL have parameter SNDW, default 16: sample width per channel.
REQ-003 SHALL have parameter SIGNED_SND, default 1'b0: 1 = input two's complement, 0 = offset binary.
REQ-004 SHALL have parameter FADEW, default 8: fade step period is 2^FADEW clocks.
REQ-005 SHALL have port clk_sys, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port snd_cen, input, 1: sample strobe; snd is valid when high.
REQ-008 SHALL have port snd, input, CHANNELS*SNDW: channel k at bits [k*SNDW +: SNDW].
REQ-009 SHALL have port mute, input, 1: level request for soft mute.
REQ-010 SHALL have port dac, output, CHANNELS: 1-bit modulator output per channel.
REQ-011 SHALL have port muted, output, 1: high only in state MUTED.
REQ-012 SHALL have port fade_busy, output, 1: high in FADE_OUT or FADE_IN.

Function
REQ-013 SHALL latch each channel on the rising edge of clk_sys where snd_cen=1 and hold it otherwise.
REQ-014 SHALL convert latched data to signed by inverting the MSB when SIGNED_SND=0.
REQ-015 SHALL scale signed samples by a 7-bit gain g (0..64): (s*g)>>>6, arithmetic shift; g=64 SHALL be bit-exact unity; g=0 SHALL give 0.
REQ-016 SHALL convert the scaled value to offset binary (MSB inverted) before modulation, so g=0 gives midscale (50% density).
REQ-017 SHALL run a first-order modulator per channel: acc[SNDW:0] <= acc[SNDW-1:0] + v, where dac = acc[SNDW], updated every clock.
REQ-018 SHALL have latency snd_cen edge -> new value entering the modulator of exactly 2 clocks (latch, scale).
REQ-019 SHALL implement a 4-state FSM: MUTED, FADE_IN, RUN, FADE_OUT.
REQ-020 SHALL transition MUTED->FADE_IN when mute=0; FADE_IN->RUN when g reaches 64; RUN->FADE_OUT when mute=1; FADE_OUT->MUTED when g reaches 0.
REQ-021 SHALL reverse direction immediately with no change to g when mute reverses during a fade (FADE_IN->FADE_OUT on mute=1; FADE_OUT->FADE_IN on mute=0).
REQ-022 SHALL step g by +/-1 in a fade state when an FADEW-bit prescaler wraps; the prescaler SHALL clear on every state change and hold at 0 outside fade states.
REQ-023 SHALL share g across all channels.
REQ-024 SHALL take no special action when snd_cen coincides with a gain step or state change; both take effect independently.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, clear latches, accumulators, dac and prescaler, set g=0 and state=MUTED (muted=1, fade_busy=0), including mid-fade; the first post-reset state change is to FADE_IN when mute=0.

Configuration
REQ-026 SHALL, with macro JTFRAME_SNDDAC_ORDER2_EN defined, replace each modulator with second-order CIFB: integrators SNDW+4 bits signed, feedback +/-2^(SNDW-1), dac = NOT MSB of integrator 2, latency per REQ-018 unchanged.
REQ-027 SHALL, without JTFRAME_SNDDAC_ORDER2_EN, use the REQ-017 first-order modulator only, with no second-order logic synthesised.

Structure
REQ-028 SHALL place the FSM state enum, GAIN_W=7 and GAIN_UNITY=64 in package jtframe_snd_pkg.
REQ-029 SHALL generate one sub-module jtframe_snddac_ch per channel, containing the latch, scale and modulator; the FSM, prescaler and gain stay in the top.

Verification
REQ-030 SHALL test reset then mute=0 with FADEW=8: fade_busy=1 after 1 clock; g reaches 64 and RUN after 64*256 clocks; muted=0.
REQ-031 SHALL test RUN, SIGNED_SND=0, snd ch0=16'hC000: dac0 density 75% +/-0.1% over 65536 clocks.
REQ-032 SHALL test RUN, SIGNED_SND=1, ch1=16'h8000: dac1 density 0% (first-order), no 1s after settling.
REQ-033 SHALL test mute=1 in RUN, then mute=0 when g=40: FADE_IN from g=40 with no jump, RUN after 24*256 clocks.
REQ-034 SHALL test rst_n=0 for 1 clock mid-FADE_OUT: next cycle shows state MUTED, dac=0, g=0, accumulators 0.
REQ-035 SHALL test MUTED with any snd: every channel density exactly 50% (alternating pattern first-order).
